// File: rtl/sideband_writer_pkg.sv
// Shared definitions for the sideband path: word layout, FSM states, length limits.
package sideband_writer_pkg;

   localparam int unsigned SB_W        = 20;
   localparam int unsigned SB_LEN_W    = 11;
   localparam int unsigned SB_DEST_W   = 4;
   localparam int unsigned SB_SRC_W    = 2;
   localparam int unsigned SB_RSVD_W   = 3;
   localparam int unsigned LEN_ACC_W   = 12;
   localparam int unsigned CNT_W       = 16;

   localparam int unsigned DEF_BYTES_PER_BEAT = 8;
   localparam int unsigned DEF_W_EMPTY        = 3;
   localparam int unsigned DEF_MIN_LEN        = 64;
   localparam int unsigned DEF_MAX_LEN        = 1522;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_COLLECT,
      ST_WAIT_DEC,
      ST_COMMIT,
      ST_DROP
   } sbw_state_e;

   typedef struct packed {
      logic [SB_RSVD_W-1:0] rsvd;
      logic [SB_SRC_W-1:0]  src;
      logic [SB_DEST_W-1:0] dest;
      logic [SB_LEN_W-1:0]  len;
   } sb_word_t;

   // Assemble one sideband word; reserved bits are always zero.
   function automatic sb_word_t sb_pack(input logic [SB_LEN_W-1:0]  len,
                                        input logic [SB_DEST_W-1:0] dest,
                                        input logic [SB_SRC_W-1:0]  src);
      sb_word_t w;
      w.rsvd = '0;
      w.src  = src;
      w.dest = dest;
      w.len  = len;
      return w;
   endfunction

endpackage

// File: rtl/sideband_writer_sat_counter.sv
// Saturating up-counter with synchronous reset.
module sideband_writer_sat_counter #(
   parameter int unsigned W = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         inc,
   output logic [W-1:0] count
);

   // Count up by one per inc, sticking at all-ones.
   always_ff @(posedge clk) begin
      if (reset) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + W'(1);
      end
   end

endmodule

// File: rtl/sideband_writer.sv
// Ingress sideband writer: measures each frame, latches the filter decision,
// and at end-of-frame either writes one sideband word or pulses a drop.
module sideband_writer
   import sideband_writer_pkg::*;
#(
   parameter int unsigned BYTES_PER_BEAT = DEF_BYTES_PER_BEAT,
   parameter int unsigned W_EMPTY        = DEF_W_EMPTY,
   parameter int unsigned MIN_LEN        = DEF_MIN_LEN,
   parameter int unsigned MAX_LEN        = DEF_MAX_LEN
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic                 in_sop,
   input  logic                 in_eop,
   input  logic [W_EMPTY-1:0]   in_empty,
   input  logic [SB_SRC_W-1:0]  in_src,
   input  logic                 dec_valid,
   input  logic                 dec_drop,
   input  logic [SB_DEST_W-1:0] dec_dest,
   output logic [SB_W-1:0]      sb_wdata,
   output logic                 sb_wen,
   input  logic                 sb_full,
   output logic                 frame_drop,
   output logic [CNT_W-1:0]     drop_count,
   output logic [CNT_W-1:0]     err_count
);

   localparam logic [LEN_ACC_W-1:0] BEAT_LEN  = LEN_ACC_W'(BYTES_PER_BEAT);
   localparam logic [LEN_ACC_W-1:0] MIN_L     = LEN_ACC_W'(MIN_LEN);
   localparam logic [LEN_ACC_W-1:0] MAX_L     = LEN_ACC_W'(MAX_LEN);

   sbw_state_e                state, state_d;
   logic [LEN_ACC_W-1:0]      len, len_d;
   logic [SB_SRC_W-1:0]       src, src_d;
   logic [SB_DEST_W-1:0]      dest, dest_d;
   logic                      dec_seen, dec_seen_d;
   logic                      dec_drop_q, dec_drop_d;
   logic                      accept, frame_start, eval_eop, dec_ok;
   logic                      err_inc, miss_eop, frame_drop_d, in_ready_d, load_word;
   logic [LEN_ACC_W-1:0]      beat_len, len_sum;
   logic [LEN_ACC_W:0]        len_acc;
   sb_word_t                  word_d;

   assign accept   = in_valid & in_ready;
   assign beat_len = in_eop ? (BEAT_LEN - LEN_ACC_W'(in_empty)) : BEAT_LEN;
   assign len_acc  = {1'b0, len} + {1'b0, beat_len};
   assign len_sum  = len_acc[LEN_ACC_W] ? '1 : len_acc[LEN_ACC_W-1:0];

   // FIFO write only while committing and the FIFO has room, so it can never hit a full FIFO.
   assign sb_wen   = (state == ST_COMMIT) & ~sb_full;

   // Next-state, frame bookkeeping, decision latch and end-of-frame evaluation.
   always_comb begin
      state_d     = state;
      len_d       = len;
      src_d       = src;
      dest_d      = dest;
      dec_seen_d  = dec_seen;
      dec_drop_d  = dec_drop_q;
      frame_start = 1'b0;
      eval_eop    = 1'b0;
      dec_ok      = 1'b0;
      err_inc     = 1'b0;
      miss_eop    = 1'b0;

      case (state)
         ST_IDLE: begin
            if (accept && in_sop) begin
               frame_start = 1'b1;
            end else if (accept) begin
               err_inc = 1'b1;
            end
            if (dec_valid && !frame_start) err_inc = 1'b1;
            dec_ok = frame_start;
         end
         ST_COLLECT: begin
            dec_ok = 1'b1;
            if (accept && in_sop) begin
               frame_start = 1'b1;
               miss_eop    = 1'b1;
               err_inc     = 1'b1;
            end else if (accept) begin
               len_d    = len_sum;
               eval_eop = in_eop;
            end
         end
         ST_WAIT_DEC: begin
            dec_ok = 1'b1;
         end
         ST_COMMIT: begin
            if (!sb_full) state_d = ST_IDLE;
            if (dec_valid) err_inc = 1'b1;
         end
         ST_DROP: begin
            state_d = ST_IDLE;
            if (dec_valid) err_inc = 1'b1;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // A sop beat opens a fresh frame context; a sop+eop beat is evaluated at once.
      if (frame_start) begin
         state_d    = ST_COLLECT;
         len_d      = beat_len;
         src_d      = in_src;
         dest_d     = '0;
         dec_seen_d = 1'b0;
         dec_drop_d = 1'b0;
         eval_eop   = in_eop;
      end

      // First decision of a frame wins; any later one is a protocol error.
      if (dec_valid && dec_ok) begin
         if (dec_seen_d) begin
            err_inc = 1'b1;
         end else begin
            dec_seen_d = 1'b1;
            dec_drop_d = dec_drop;
            dest_d     = dec_dest;
         end
      end

      if ((state == ST_WAIT_DEC) && dec_seen_d) begin
         state_d = dec_drop_d ? ST_DROP : ST_COMMIT;
      end

      if (eval_eop) begin
         if ((len_d < MIN_L) || (len_d > MAX_L) || (dec_seen_d && dec_drop_d)) begin
            state_d = ST_DROP;
         end else if (!dec_seen_d) begin
            state_d = ST_WAIT_DEC;
         end else begin
            state_d = ST_COMMIT;
         end
      end
   end

   assign frame_drop_d = miss_eop | (state_d == ST_DROP);
   assign in_ready_d   = (state_d == ST_IDLE) | (state_d == ST_COLLECT);
   assign load_word    = (state_d == ST_COMMIT) & (state != ST_COMMIT);
   assign word_d       = sb_pack(len_d[SB_LEN_W-1:0], dest_d, src_d);

   // State, frame context and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= ST_IDLE;
         len        <= '0;
         src        <= '0;
         dest       <= '0;
         dec_seen   <= 1'b0;
         dec_drop_q <= 1'b0;
         in_ready   <= 1'b1;
         frame_drop <= 1'b0;
         sb_wdata   <= '0;
      end else begin
         state      <= state_d;
         len        <= len_d;
         src        <= src_d;
         dest       <= dest_d;
         dec_seen   <= dec_seen_d;
         dec_drop_q <= dec_drop_d;
         in_ready   <= in_ready_d;
         frame_drop <= frame_drop_d;
         if (load_word) sb_wdata <= word_d;
      end
   end

   sideband_writer_sat_counter #(.W(CNT_W)) u_drop_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (frame_drop_d),
      .count (drop_count)
   );

   sideband_writer_sat_counter #(.W(CNT_W)) u_err_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (err_inc),
      .count (err_count)
   );

endmodule

// File: tb/tb_sideband_writer.sv
// Bench for sideband_writer: frame-level reference model with an output scoreboard.
module tb_sideband_writer;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid, in_ready, in_sop, in_eop;
   logic [2:0]  in_empty;
   logic [1:0]  in_src;
   logic        dec_valid, dec_drop;
   logic [3:0]  dec_dest;
   logic [19:0] sb_wdata;
   logic        sb_wen, sb_full, frame_drop;
   logic [15:0] drop_count, err_count;

   int n_vec = 0;
   int n_bad = 0;
   bit mon_en = 1'b0;
   bit rand_full = 1'b0;

   typedef struct {
      bit          drop;
      logic [19:0] word;
   } ev_t;

   ev_t exp_q[$];
   int  exp_drops = 0;
   int  exp_errs  = 0;

   sideband_writer dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_sop     (in_sop),
      .in_eop     (in_eop),
      .in_empty   (in_empty),
      .in_src     (in_src),
      .dec_valid  (dec_valid),
      .dec_drop   (dec_drop),
      .dec_dest   (dec_dest),
      .sb_wdata   (sb_wdata),
      .sb_wen     (sb_wen),
      .sb_full    (sb_full),
      .frame_drop (frame_drop),
      .drop_count (drop_count),
      .err_count  (err_count)
   );

   always #5 clk = ~clk;

   function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endfunction

   // Frame outcome from the rules: legal length and no drop decision -> one word.
   function automatic void push_frame(input int len, input logic [1:0] src,
                                      input logic [3:0] dest, input bit drop);
      ev_t e;
      e.drop = (len < 64) || (len > 1522) || drop;
      e.word = e.drop ? 20'h0 : {3'b000, src, dest, 11'(len)};
      if (e.drop) exp_drops++;
      exp_q.push_back(e);
   endfunction

   // Every cycle: invariants, and each write/drop must match the next expected frame.
   always @(negedge clk) begin : monitor
      ev_t e;
      if (!reset && mon_en) begin
         chk("wen_and_drop", 32'(sb_wen & frame_drop), 32'd0);
         chk("wen_while_full", 32'(sb_wen & sb_full), 32'd0);
         if (sb_wen || frame_drop) begin
            if (exp_q.size() == 0) begin
               n_vec++;
               n_bad++;
               $display("FAIL unexpected_output: wen=%0d drop=%0d, expected no frame pending", sb_wen, frame_drop);
            end else begin
               e = exp_q.pop_front();
               chk("outcome_kind", 32'(frame_drop), 32'(e.drop));
               if (!e.drop) chk("sb_wdata", 32'(sb_wdata), 32'(e.word));
            end
         end
      end
   end

   task automatic drive_beat(input bit sop, input bit eop, input logic [2:0] emp,
                             input logic [1:0] src, input bit dv, input bit dd,
                             input logic [3:0] dest);
      int g;
      in_valid = 1'b1;
      in_sop   = sop;
      in_eop   = eop;
      in_empty = emp;
      in_src   = src;
      g = 0;
      forever begin
         @(negedge clk);
         if (in_ready) break;
         @(posedge clk); #1;
         g++;
         if (g > 200) begin
            chk("accept_timeout", 32'(in_ready), 32'd1);
            break;
         end
      end
      if (dv) begin
         dec_valid = 1'b1;
         dec_drop  = dd;
         dec_dest  = dest;
      end
      @(posedge clk); #1;
      in_valid  = 1'b0;
      in_sop    = 1'b0;
      in_eop    = 1'b0;
      dec_valid = 1'b0;
   endtask

   // dec_beat < 0 means the decision arrives late_delay cycles after eop (if the length is legal).
   task automatic send_frame(input int nb, input int emp, input logic [1:0] src,
                             input logic [3:0] dest, input int dec_beat, input bit dd,
                             input int late_delay, input bit gaps, input bit push);
      int len;
      bit late;
      len  = nb * 8 - emp;
      late = (dec_beat < 0) && (len >= 64) && (len <= 1522);
      if (push) push_frame(len, src, dest, dd);
      for (int i = 0; i < nb; i++) begin
         drive_beat(i == 0, i == nb - 1, (i == nb - 1) ? 3'(emp) : 3'($urandom),
                    src, i == dec_beat, dd, dest);
         if (gaps && (i < nb - 1) && ($urandom % 4 == 0)) begin
            @(posedge clk); #1;
         end
      end
      if (late) begin
         repeat (late_delay) begin
            @(negedge clk);
            chk("wait_dec_ready", 32'(in_ready), 32'd0);
            @(posedge clk); #1;
         end
         dec_valid = 1'b1;
         dec_drop  = dd;
         dec_dest  = dest;
         @(posedge clk); #1;
         dec_valid = 1'b0;
      end
   endtask

   task automatic settle();
      int g;
      g = 0;
      while ((exp_q.size() > 0) && (g < 500)) begin
         @(posedge clk);
         g++;
      end
      chk("settle_pending", 32'(exp_q.size()), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      chk("drop_count_model", 32'(drop_count), 32'(exp_drops));
      chk("err_count_model", 32'(err_count), 32'(exp_errs));
   endtask

   task automatic do_reset();
      reset = 1'b1;
      exp_q.delete();
      exp_drops = 0;
      exp_errs  = 0;
      @(posedge clk); #1;
      reset = 1'b0;
   endtask

   task automatic check_reset_values(input string tag);
      @(negedge clk);
      chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
      chk({tag, "_sb_wen"}, 32'(sb_wen), 32'd0);
      chk({tag, "_frame_drop"}, 32'(frame_drop), 32'd0);
      chk({tag, "_sb_wdata"}, 32'(sb_wdata), 32'd0);
      chk({tag, "_drop_count"}, 32'(drop_count), 32'd0);
      chk({tag, "_err_count"}, 32'(err_count), 32'd0);
   endtask

   initial begin
      int nb, r;
      reset = 1'b1;
      in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; in_empty = '0; in_src = '0;
      dec_valid = 1'b0; dec_drop = 1'b0; dec_dest = '0; sb_full = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      check_reset_values("reset");
      @(posedge clk); #1;
      mon_en = 1'b1;

      // 62-byte runt with keep decision: dropped one cycle after eop.
      send_frame(8, 2, 2'd1, 4'b0010, 1, 1'b0, 0, 1'b0, 1'b1);
      @(negedge clk);
      chk("runt_drop", 32'(frame_drop), 32'd1);
      chk("runt_no_wen", 32'(sb_wen), 32'd0);
      chk("runt_drop_count", 32'(drop_count), 32'd1);
      @(posedge clk); #1;

      // 70-byte frame: one write one cycle after eop with the literal word.
      send_frame(9, 2, 2'd1, 4'b0010, 1, 1'b0, 0, 1'b0, 1'b1);
      @(negedge clk);
      chk("commit_wen", 32'(sb_wen), 32'd1);
      chk("commit_word", 32'(sb_wdata), 32'h09046);
      @(posedge clk); #1;

      // FIFO full for 5 cycles after eop: stall, then write, then ready again.
      sb_full = 1'b1;
      send_frame(9, 2, 2'd1, 4'b0010, 1, 1'b0, 0, 1'b0, 1'b1);
      repeat (5) begin
         @(negedge clk);
         chk("full_ready_low", 32'(in_ready), 32'd0);
         chk("full_no_wen", 32'(sb_wen), 32'd0);
         @(posedge clk); #1;
      end
      sb_full = 1'b0;
      @(negedge clk);
      chk("full_release_wen", 32'(sb_wen), 32'd1);
      @(posedge clk); #1;
      @(negedge clk);
      chk("full_release_ready", 32'(in_ready), 32'd1);
      @(posedge clk); #1;

      // No decision by eop: wait 3 cycles with in_ready low, then a drop decision.
      send_frame(9, 0, 2'd2, 4'b1000, -1, 1'b1, 3, 1'b0, 1'b1);
      @(negedge clk);
      chk("late_drop", 32'(frame_drop), 32'd1);
      chk("late_drop_count", 32'(drop_count), 32'd2);
      @(posedge clk); #1;

      // 1600-byte oversize frame with keep decision is dropped.
      send_frame(200, 0, 2'd3, 4'b0100, 5, 1'b0, 0, 1'b0, 1'b1);
      @(negedge clk);
      chk("oversize_drop", 32'(frame_drop), 32'd1);
      chk("oversize_no_wen", 32'(sb_wen), 32'd0);
      chk("oversize_drop_count", 32'(drop_count), 32'd3);
      chk("no_errors_yet", 32'(err_count), 32'd0);
      @(posedge clk); #1;
      settle();

      // Randomized frames with gaps, random decisions and a random FIFO-full pattern.
      rand_full = 1'b1;
      fork
         begin
            while (rand_full) begin
               @(posedge clk); #1;
               sb_full = ($urandom % 3 == 0);
            end
            sb_full = 1'b0;
         end
      join_none
      for (int f = 0; f < 60; f++) begin
         r = int'($urandom % 10);
         if (r == 0)      nb = int'($urandom_range(1, 8));
         else if (r == 1) nb = int'($urandom_range(185, 200));
         else             nb = int'($urandom_range(8, 40));
         send_frame(nb, int'($urandom_range(0, 7)), 2'($urandom), 4'($urandom_range(1, 15)),
                    ($urandom % 3 == 0) ? -1 : int'($urandom_range(0, nb - 1)),
                    ($urandom % 4 == 0), int'($urandom_range(0, 3)), 1'b1, 1'b1);
         repeat ($urandom % 3) begin
            @(posedge clk); #1;
         end
      end
      rand_full = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      settle();

      // Missing eop then a stray non-sop beat in idle.
      do_reset();
      begin
         ev_t e;
         e.drop = 1'b1;
         e.word = 20'h0;
         exp_q.push_back(e);
         exp_drops++;
         exp_errs++;
      end
      for (int i = 0; i < 3; i++) drive_beat(i == 0, 1'b0, 3'd0, 2'd3, 1'b0, 1'b0, 4'd0);
      send_frame(9, 2, 2'd2, 4'b0001, 1, 1'b0, 0, 1'b0, 1'b1);
      settle();
      drive_beat(1'b0, 1'b0, 3'd0, 2'd0, 1'b0, 1'b0, 4'd0);
      exp_errs++;
      repeat (2) @(posedge clk);
      #1;
      chk("stray_err_count", 32'(err_count), 32'd2);
      chk("stray_drop_count", 32'(drop_count), 32'd1);
      settle();

      // Reset while committing into a full FIFO abandons the frame silently.
      do_reset();
      sb_full = 1'b1;
      send_frame(9, 2, 2'd1, 4'b0010, 1, 1'b0, 0, 1'b0, 1'b0);
      @(negedge clk);
      chk("commit_held_full", 32'(sb_wen), 32'd0);
      chk("commit_ready_low", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      sb_full = 1'b0;
      check_reset_values("midreset");
      repeat (10) @(posedge clk);
      #1;
      settle();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
